ram_loader: RTL

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader_pkg.sv | 24 ++
 rtl/ram_loader_if.sv | 36 +++
 rtl/ram_loader_sum.sv | 31 +++
 rtl/ram_loader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM loader: state encoding, default geometry
// of the loader/RAM pair, and a small state-decoding helper.
package ram_loader_pkg;

  localparam int RAM_WIDTH_DEF     = 8;
  localparam int RAM_ADDR_BITS_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // A load is in progress while the loader is accepting data or verifying it.
  function automatic logic state_is_busy(input state_t st);
    case (st)
      ST_LOAD, ST_CHECK, ST_VERIFY: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ram_loader_if.sv
// Bundle of the loader's control, upstream stream, RAM port and status
// signals. The master modport is the loader itself; slave is its environment.
interface ram_loader_if
  import ram_loader_pkg::*;
#(
  parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) ();

  logic                     start;
  logic [RAM_ADDR_BITS:0]   load_count;
  logic                     in_valid;
  logic [RAM_WIDTH-1:0]     in_data;
  logic                     in_ready;
  logic                     ram_write_enable;
  logic [RAM_ADDR_BITS-1:0] ram_address;
  logic [RAM_WIDTH-1:0]     ram_input_data;
  logic [RAM_WIDTH-1:0]     ram_output_data;
  logic                     cpu_hold;
  logic                     busy;
  logic                     done;
  logic                     error;

  modport master (
    input  start, load_count, in_valid, in_data, ram_output_data,
    output in_ready, ram_write_enable, ram_address, ram_input_data,
    output cpu_hold, busy, done, error
  );

  modport slave (
    output start, load_count, in_valid, in_data, ram_output_data,
    input  in_ready, ram_write_enable, ram_address, ram_input_data,
    input  cpu_hold, busy, done, error
  );

endinterface

// File: rtl/ram_loader_sum.sv
// Clearable running sum modulo 2**WIDTH. Clear wins over enable so a new
// load always starts from zero even if a stray enable coincides with it.
module ram_loader_sum #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] sum_r;

  // Accumulate din when enabled; the adder wraps naturally at WIDTH bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      sum_r <= {WIDTH{1'b0}};
    end else if (en) begin
      sum_r <= sum_r + din;
    end else begin
      sum_r <= sum_r;
    end
  end

  assign sum = sum_r;

endmodule

// File: rtl/ram_loader.sv
// RAM loader: copies N words from a valid/ready stream into a RAM, takes one
// checksum word, reads the RAM back and releases the CPU only when both the
// stream checksum and the read-back sum agree with what was written.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_DEF
) (
  input logic          clk,
  input logic          reset,
  ram_loader_if.master bus
);

  localparam int CNT_BITS = RAM_ADDR_BITS + 1;
  localparam logic [CNT_BITS-1:0] N_MAX = CNT_BITS'(2 ** RAM_ADDR_BITS);

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [RAM_ADDR_BITS-1:0] addr_r;
  logic [CNT_BITS-1:0]      count_r;
  logic [CNT_BITS-1:0]      vcnt_r;
  logic [RAM_WIDTH-1:0]     checksum_r;
  logic                     error_r;
  logic                     cpu_hold_r;

  logic [RAM_WIDTH-1:0]     write_sum_s;
  logic [RAM_WIDTH-1:0]     read_sum_s;
  logic [RAM_WIDTH-1:0]     read_final_s;
  logic                     count_bad_s;
  logic                     start_acc_s;
  logic                     load_last_s;
  logic                     verify_last_s;
  logic                     verify_err_s;
  logic                     xfer_s;
  logic                     in_ready_s;
  logic                     we_s;
  logic [RAM_ADDR_BITS-1:0] addr_out_s;
  logic [RAM_WIDTH-1:0]     wdata_s;

  assign count_bad_s   = (bus.load_count == {CNT_BITS{1'b0}}) || (bus.load_count > N_MAX);
  assign start_acc_s   = (state_r == ST_IDLE) && bus.start;
  // addr_r is one bit narrower than count_r so that N_MAX wraps to 0 after the last write.
  assign load_last_s   = ({1'b0, addr_r} == (count_r - CNT_BITS'(1)));
  assign verify_last_s = (vcnt_r == count_r);
  // The last read word arrives in the final VERIFY cycle, so fold it in here.
  assign read_final_s  = read_sum_s + bus.ram_output_data;
  assign verify_err_s  = (checksum_r != write_sum_s) || (read_final_s != write_sum_s);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-state drive of the stream and RAM write port.
  always_comb begin
    state_nxt_s = state_r;
    in_ready_s  = 1'b0;
    we_s        = 1'b0;
    addr_out_s  = {RAM_ADDR_BITS{1'b0}};
    wdata_s     = {RAM_WIDTH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = count_bad_s ? ST_DONE : ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        in_ready_s = 1'b1;
        addr_out_s = addr_r;
        if (bus.in_valid) begin
          we_s        = 1'b1;
          wdata_s     = bus.in_data;
          state_nxt_s = load_last_s ? ST_CHECK : ST_LOAD;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_CHECK: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          state_nxt_s = ST_VERIFY;
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
      ST_VERIFY: begin
        addr_out_s  = vcnt_r[RAM_ADDR_BITS-1:0];
        state_nxt_s = verify_last_s ? ST_DONE : ST_VERIFY;
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign xfer_s = in_ready_s && bus.in_valid && !reset;

  // Load bookkeeping: word count, write address, checksum, verdict and CPU hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r     <= {RAM_ADDR_BITS{1'b0}};
      count_r    <= {CNT_BITS{1'b0}};
      vcnt_r     <= {CNT_BITS{1'b0}};
      checksum_r <= {RAM_WIDTH{1'b0}};
      error_r    <= 1'b0;
      cpu_hold_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            count_r    <= bus.load_count;
            addr_r     <= {RAM_ADDR_BITS{1'b0}};
            vcnt_r     <= {CNT_BITS{1'b0}};
            error_r    <= count_bad_s;
            cpu_hold_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (xfer_s) begin
            addr_r <= addr_r + RAM_ADDR_BITS'(1);
          end
        end
        ST_CHECK: begin
          if (xfer_s) begin
            checksum_r <= bus.in_data;
            addr_r     <= {RAM_ADDR_BITS{1'b0}};
            vcnt_r     <= {CNT_BITS{1'b0}};
          end
        end
        ST_VERIFY: begin
          vcnt_r <= vcnt_r + CNT_BITS'(1);
          if (verify_last_s) begin
            error_r    <= verify_err_s;
            cpu_hold_r <= verify_err_s;
          end
        end
        ST_DONE: begin
          vcnt_r <= {CNT_BITS{1'b0}};
        end
        default: begin
          addr_r <= {RAM_ADDR_BITS{1'b0}};
        end
      endcase
    end
  end

  ram_loader_sum #(.WIDTH(RAM_WIDTH)) u_write_sum (
    .clk   (clk),
    .reset (reset),
    .clear (start_acc_s),
    .en    (xfer_s && (state_r == ST_LOAD)),
    .din   (bus.in_data),
    .sum   (write_sum_s)
  );

  ram_loader_sum #(.WIDTH(RAM_WIDTH)) u_read_sum (
    .clk   (clk),
    .reset (reset),
    .clear (start_acc_s),
    .en    ((state_r == ST_VERIFY) && (vcnt_r != {CNT_BITS{1'b0}})),
    .din   (bus.ram_output_data),
    .sum   (read_sum_s)
  );

  // Reset overrides everything visible in the same cycle, including an in-flight handshake.
  assign bus.in_ready         = in_ready_s && !reset;
  assign bus.ram_write_enable = we_s && !reset;
  assign bus.ram_address      = reset ? {RAM_ADDR_BITS{1'b0}} : addr_out_s;
  assign bus.ram_input_data   = reset ? {RAM_WIDTH{1'b0}} : wdata_s;
  assign bus.busy             = state_is_busy(state_r) && !reset;
  assign bus.done             = (state_r == ST_DONE) && !reset;
  assign bus.error            = error_r && !reset;
  assign bus.cpu_hold         = cpu_hold_r || reset;

endmodule
